// File: rtl/riv_stage_buffer.sv
// -----------------------------------------------------------------------------
// riv_stage_buffer
//
// Elastic buffer that sits on a pipeline stage boundary of the riviera core
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It is a DEPTH-entry circular FIFO with a
// valid/ready handshake on both sides. A flush input kills everything held,
// and an optional full-bypass mode lets the buffer take a new entry while
// full, provided the head leaves in the same cycle.
//
// Handshake rules (both sides use the same valid/ready contract):
//   - A transfer happens on a rising edge where valid and ready are both high
//     and i_flush is low. Valid must not depend on ready. Once valid is
//     raised it stays up, with its payload unchanged, until the transfer.
//   - Upstream side:   i_valid / i_data  ->  o_ready
//   - Downstream side: o_valid / o_data  ->  i_ready
//   - A cycle with i_flush high completes no transfer on either side.
//     Upstream treats it as consumed, and o_drop reports any payload lost.
//
// Parameters:
//   DATA_W        payload width in bits (>= 1)
//   DEPTH         number of entries (power of two, >= 2)
//   FULL_PUSH_EN  1: accept a push while full if a pop happens that cycle
//   CNT_W         occupancy counter width (derived, do not override)
//
// Ports:
//   clk      in   core clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_valid  in   upstream has a payload
//   i_data   in   upstream payload
//   o_ready  out  buffer can accept this cycle
//   o_valid  out  head entry is valid
//   o_data   out  head entry payload
//   i_ready  in   downstream accepts the head this cycle
//   i_flush  in   discard all entries (branch/jump taken in EX)
//   o_count  out  current occupancy
//   o_drop   out  one-cycle pulse: i_valid was high during a flush cycle
// -----------------------------------------------------------------------------
module riv_stage_buffer #(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 2,
    parameter int FULL_PUSH_EN = 0,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    input  logic              i_flush,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_drop
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Payload storage. It has no reset because entries are only read while
    // count says they are live.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              drop_q;

    logic              not_full;
    logic              push;
    logic              pop;

    // Occupancy is kept in its own counter rather than derived from the
    // pointers. When rd_ptr == wr_ptr, this tells full apart from empty.
    assign not_full = (count != DEPTH_C);

    generate
        if (FULL_PUSH_EN != 0) begin : g_full_push
            // Combinational path from i_ready to o_ready. A full buffer can
            // take a new entry when the head is leaving in the same cycle.
            assign o_ready = not_full | i_ready;
        end else begin : g_no_full_push
            assign o_ready = not_full;
        end
    endgenerate

    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign o_count = count;
    assign o_drop  = drop_q;

    assign push = i_valid & o_ready & ~i_flush;
    assign pop  = o_valid & i_ready & ~i_flush;

    // Storage write. On a full bypass, wr_ptr == rd_ptr. The old head is
    // presented on o_data during this cycle and is overwritten only at the
    // edge that also retires it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= i_valid & i_flush;
            if (i_flush) begin
                // Empty the buffer without moving the pointers back to 0.
                // Collapsing rd_ptr onto wr_ptr is enough.
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                // DEPTH is a power of two, so pointer increment wraps
                // naturally from DEPTH-1 to 0.
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: doc/riv_stage_buffer.md
Name: riv_stage_buffer

Overview:
- Parametrised elastic buffer placed between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the riviera core.
- Replaces the fixed single-register stage boundaries with a configurable-depth FIFO using a valid/ready handshake.
- Provides a flush input, driven by EX branch/jump taken, that kills all buffered entries.
- Provides an optional full-bypass mode, so a stage can accept while full if downstream drains in the same cycle.

Parameters:
- DATA_W, 64, payload width in bits (holds packed stage struct); must be >= 1.
- DEPTH, 2, number of entries; power of two, >= 2.
- FULL_PUSH_EN, 0, when 1 the buffer accepts a push while full if a pop occurs in the same cycle.
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; do not override).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream has a payload.
- i_data  input  DATA_W  upstream payload.
- o_ready  output  1  buffer can accept this cycle.
- o_valid  output  1  head entry is valid.
- o_data  output  DATA_W  head entry payload.
- i_ready  input  1  downstream accepts head this cycle.
- i_flush  input  1  discard all entries (branch/jump taken).
- o_count  output  CNT_W  current occupancy.
- o_drop  output  1  one-cycle pulse: i_valid was asserted while i_flush was high (push dropped).

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - Read/write pointers go to 0 and count goes to 0.
  - o_valid=0, o_count=0, o_drop=0.
  - o_ready=1.
  - o_data contents are don't-care; the bench must not check o_data while o_valid=0.
- Reset asserted mid-transfer discards all entries immediately. No handshake completes in that cycle.
- Storage is a circular array of DEPTH entries. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Count is updated separately (not derived from pointers), so full and empty are unambiguous.
- push = i_valid & o_ready & ~i_flush.
- pop = o_valid & i_ready & ~i_flush.
- o_valid = (count != 0); o_data = mem[rd_ptr]. Both are combinational from registered state.
- Latency: a payload pushed in cycle N appears at o_valid/o_data in cycle N+1. There is no same-cycle pass-through.
- o_ready rules:
  - FULL_PUSH_EN=0: o_ready = (count != DEPTH). It does not depend on i_ready.
  - FULL_PUSH_EN=1: o_ready = (count != DEPTH) | i_ready. This is a combinational path from i_ready; integrators must avoid loops.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - When full with FULL_PUSH_EN=1, the write goes to the slot being vacated (wr_ptr == rd_ptr); the old head is read before it is overwritten.
- Empty with i_ready high: no pop and no pointer change.
- Flush:
  - At the next edge, count=0 and rd_ptr=wr_ptr (pointer values need not return to 0).
  - A push or pop in the flush cycle is suppressed.
  - o_drop=1 in the following cycle if i_valid was high during the flush cycle; otherwise o_drop=0.
  - o_ready is still driven normally during the flush cycle; upstream treats a flushed cycle as consumed.
- Count never exceeds DEPTH and never underflows. Write-when-full with no pop, and read-when-empty, are blocked by the handshake.
- All state is updated only on the rising edge of clk, apart from the asynchronous reset.

Test Plan:
- Reset and fill, DEPTH=2, FULL_PUSH_EN=0, i_ready=0:
  - After rst_n is released, o_ready=1, o_valid=0, o_count=0.
  - Push 0xA then 0xB: o_count 1, then 2; o_ready=0 after the second push.
  - A third push with i_valid=1 is not accepted and o_count stays 2.
- Drain in order: from the full state, i_ready=1 for 2 cycles.
  - o_data sequence is 0xA, then 0xB.
  - o_valid=0 and o_count=0 afterwards; o_ready=1 again.
- Streaming with wrap-around, DEPTH=4: push 10 consecutive values 1..10 with i_ready=1 throughout.
  - o_data shows 1..10 in order, each one cycle after its push.
  - o_count holds at 1 in steady state; pointers wrap twice with no loss.
- Full bypass, DEPTH=2, FULL_PUSH_EN=1: fill with 0x1, 0x2, then assert i_valid (0x3) and i_ready together.
  - o_ready=1 while full.
  - 0x1 pops, 0x3 is accepted, o_count stays 2.
  - Subsequent drain order is 0x2, 0x3.
- Flush with concurrent push: hold 2 entries, assert i_flush with i_valid=1 (0x7) and i_ready=1.
  - Next cycle: o_count=0, o_valid=0, o_drop=1 for exactly one cycle.
  - 0x7 never appears on o_data.
- Asynchronous reset mid-operation: with 3 entries in DEPTH=4, drop rst_n between clock edges.
  - o_valid and o_count go to 0 without waiting for a clock edge.
  - After release, the first pushed value is the first popped.
